// File: rtl/regs_rsp_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : regs_rsp_slave_if
// Description : Register command bus between an initiator and the
//               regs_rsp_slave responder, including the transaction counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface regs_rsp_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [1:0]        cmd_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic [DATA_W-1:0] cmd_data_o;
    logic              cmd_rvalid_o;
    logic              cmd_err_o;
    logic              cnt_clr_i;
    logic [15:0]       wr_cnt_o;
    logic [15:0]       rd_cnt_o;
    logic [7:0]        err_cnt_o;

    // Initiator side: issues commands, observes responses and counters
    modport master (
        output cmd_i, cmd_addr_i, cmd_data_i, cnt_clr_i,
        input  cmd_data_o, cmd_rvalid_o, cmd_err_o,
        input  wr_cnt_o, rd_cnt_o, err_cnt_o
    );

    // Responder side: decodes commands, produces responses and counters
    modport slave (
        input  cmd_i, cmd_addr_i, cmd_data_i, cnt_clr_i,
        output cmd_data_o, cmd_rvalid_o, cmd_err_o,
        output wr_cnt_o, rd_cnt_o, err_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/regs_rsp_slave.sv
`default_nettype none
// ============================================================================
// Module      : regs_rsp_slave
// Description : Register command responder. Decodes IDLE/RD/WR into a small
//               register bank, returns read data with one-cycle latency,
//               flags protocol errors and keeps saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module regs_rsp_slave #(
    parameter int                   ADDR_W   = 8,
    parameter int                   DATA_W   = 32,
    parameter int                   NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = 8'h80,
    parameter logic [DATA_W-1:0]    ID_VAL   = 32'h5245_4753,
    parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEAD_BEEF
) (
    input  wire logic        clk_i,
    input  wire logic        rstn_i,
    regs_rsp_slave_if.slave  bus
);

    localparam logic [1:0] c_CMD_IDLE = 2'b00;
    localparam logic [1:0] c_CMD_RD   = 2'b01;
    localparam logic [1:0] c_CMD_WR   = 2'b10;
    localparam logic [1:0] c_CMD_BAD  = 2'b11;
    localparam int         c_IDX_W    = ADDR_W - 2;

    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [DATA_W-1:0]  r_data;
    logic               r_rvalid;
    logic               r_err;
    logic [15:0]        r_wr_cnt;
    logic [15:0]        r_rd_cnt;
    logic [7:0]         r_err_cnt;

    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_in_range;
    logic               w_ro_hit;
    logic               w_active;
    logic               w_is_rd;
    logic               w_is_wr;
    logic               w_err;
    logic               w_rd_ok;
    logic               w_wr_ok;

    assign w_idx    = bus.cmd_addr_i[ADDR_W-1:2];
    assign w_active = (bus.cmd_i != c_CMD_IDLE);
    assign w_is_rd  = (bus.cmd_i == c_CMD_RD);
    assign w_is_wr  = (bus.cmd_i == c_CMD_WR);

    // Word decode: selected register contents, range hit and read-only flag
    always_comb begin
        w_rd_data  = '0;
        w_in_range = 1'b0;
        w_ro_hit   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == c_IDX_W'(i)) begin
                w_rd_data  = r_regs[i];
                w_in_range = 1'b1;
                w_ro_hit   = RO_MASK[i];
            end
        end
    end

    // Error classification; IDLE never errors since its address is don't-care
    assign w_err   = w_active && ((bus.cmd_i == c_CMD_BAD)
                                  || (bus.cmd_addr_i[1:0] != 2'b00)
                                  || !w_in_range
                                  || (w_is_wr && w_ro_hit));
    assign w_rd_ok = w_is_rd && !w_err;
    assign w_wr_ok = w_is_wr && !w_err;

    // Register bank: RW words written on a clean WR, RO words pinned to ID_VAL
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rstn_i) begin
                r_regs[i] <= RO_MASK[i] ? ID_VAL : '0;
            end else if (w_wr_ok && (w_idx == c_IDX_W'(i)) && !RO_MASK[i]) begin
                r_regs[i] <= bus.cmd_data_i;
            end
        end
    end

    // Read response: data holds between reads, strobes pulse for one cycle
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_data   <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_is_rd;
            r_err    <= w_err;
            if (w_rd_ok) begin
                r_data <= w_rd_data;
            end else if (w_is_rd) begin
                r_data <= ERR_DATA;
            end
        end
    end

    // Saturating transaction counters; clear wins over a same-cycle increment
    always_ff @(posedge clk_i) begin
        if (!rstn_i || bus.cnt_clr_i) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_wr_ok && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_rd_ok && (r_rd_cnt != 16'hFFFF)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.cmd_data_o   = r_data;
    assign bus.cmd_rvalid_o = r_rvalid;
    assign bus.cmd_err_o    = r_err;
    assign bus.wr_cnt_o     = r_wr_cnt;
    assign bus.rd_cnt_o     = r_rd_cnt;
    assign bus.err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regs_rsp_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_regs_rsp_slave
// Description : Self-checking bench for regs_rsp_slave: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regs_rsp_slave;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RD   = 2'b01;
    localparam logic [1:0] c_WR   = 2'b10;
    localparam logic [1:0] c_BAD  = 2'b11;

    logic clk;
    logic rstn;

    regs_rsp_slave_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    regs_rsp_slave dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Behavioural model state
    logic [31:0] m_regs [8];
    logic [31:0] m_data;
    bit          m_rvalid;
    bit          m_err;
    int          m_wr;
    int          m_rd;
    int          m_errs;
    logic [7:0]  m_ro;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int sat(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    // Model of one clock edge, working from the command's meaning
    task automatic model(input logic [1:0] c, input logic [7:0] a,
                         input logic [31:0] d, input bit clr, input bit rs);
        int  idx;
        bit  bad;
        idx = int'(a) / 4;
        if (!rs) begin
            for (int i = 0; i < 8; i++) m_regs[i] = m_ro[i] ? 32'h5245_4753 : 32'h0;
            m_data = 0; m_rvalid = 0; m_err = 0; m_wr = 0; m_rd = 0; m_errs = 0;
            return;
        end
        m_rvalid = (c == c_RD);
        m_err    = 0;
        if (c != c_IDLE) begin
            bad = (c == c_BAD) || (int'(a) % 4 != 0) || (idx >= 8)
                  || (c == c_WR && idx < 8 && m_ro[idx]);
            if (bad) begin
                m_err  = 1;
                m_errs = sat(m_errs, 255);
                if (c == c_RD) m_data = 32'hDEAD_BEEF;
            end else if (c == c_RD) begin
                m_data = m_regs[idx];
                m_rd   = sat(m_rd, 65535);
            end else begin
                m_regs[idx] = d;
                m_wr        = sat(m_wr, 65535);
            end
        end
        if (clr) begin
            m_wr = 0; m_rd = 0; m_errs = 0;
        end
    endtask

    // Drive one command, let it be sampled, then compare every output
    task automatic step(input logic [1:0] c, input logic [7:0] a,
                        input logic [31:0] d, input bit clr, input bit rs);
        bus.cmd_i      = c;
        bus.cmd_addr_i = a;
        bus.cmd_data_i = d;
        bus.cnt_clr_i  = clr;
        rstn           = rs;
        @(posedge clk);
        #1;
        model(c, a, d, clr, rs);
        chk("rvalid",  {31'b0, bus.cmd_rvalid_o}, {31'b0, m_rvalid});
        chk("err",     {31'b0, bus.cmd_err_o},    {31'b0, m_err});
        chk("data",    bus.cmd_data_o,            m_data);
        chk("wr_cnt",  {16'b0, bus.wr_cnt_o},     32'(m_wr));
        chk("rd_cnt",  {16'b0, bus.rd_cnt_o},     32'(m_rd));
        chk("err_cnt", {24'b0, bus.err_cnt_o},    32'(m_errs));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_ro    = 8'h80;
        model(c_IDLE, 8'h00, 32'h0, 1'b0, 1'b0);

        // Reset
        step(c_IDLE, 8'h00, 32'h0, 1'b0, 1'b0);
        step(c_IDLE, 8'h00, 32'h0, 1'b0, 1'b0);

        // Basic write/read with one-cycle latency
        step(c_WR,   8'h00, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(c_RD,   8'h00, 32'h0, 1'b0, 1'b1);
        step(c_IDLE, 8'h00, 32'h0, 1'b0, 1'b1);
        chk("dir_rd0", bus.cmd_data_o, 32'hFFFF_FFFF);
        chk("dir_wrc", {16'b0, bus.wr_cnt_o}, 32'd1);

        // Read-after-write, then the read-only ID register
        step(c_WR,   8'h04, 32'h1234_5678, 1'b0, 1'b1);
        step(c_RD,   8'h04, 32'h0, 1'b0, 1'b1);
        chk("dir_raw", bus.cmd_data_o, 32'h1234_5678);
        step(c_RD,   8'h1C, 32'h0, 1'b0, 1'b1);
        chk("dir_id", bus.cmd_data_o, 32'h5245_4753);

        // Four error flavours: RO write, invalid cmd, misaligned, out of range
        step(c_WR,   8'h1C, 32'h0, 1'b0, 1'b1);
        step(c_BAD,  8'h00, 32'h0, 1'b0, 1'b1);
        step(c_RD,   8'h02, 32'h0, 1'b0, 1'b1);
        chk("dir_eal", bus.cmd_data_o, 32'hDEAD_BEEF);
        step(c_RD,   8'h20, 32'h0, 1'b0, 1'b1);
        step(c_RD,   8'h1C, 32'h0, 1'b0, 1'b1);
        chk("dir_ro", bus.cmd_data_o, 32'h5245_4753);
        chk("dir_e4", {24'b0, bus.err_cnt_o}, 32'd4);

        // Error counter saturation
        for (int i = 0; i < 260; i++) step(c_BAD, 8'h00, 32'h0, 1'b0, 1'b1);
        chk("dir_esat", {24'b0, bus.err_cnt_o}, 32'hFF);

        // Clear together with a valid write
        step(c_WR,   8'h08, 32'hCAFE_F00D, 1'b1, 1'b1);
        chk("dir_clr", {16'b0, bus.wr_cnt_o}, 32'd0);
        step(c_RD,   8'h08, 32'h0, 1'b0, 1'b1);
        chk("dir_clrw", bus.cmd_data_o, 32'hCAFE_F00D);

        // Random traffic, mostly legal addresses
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  c;
            logic [7:0]  a;
            int          sel;
            c   = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel < 7) a = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
            else         a = 8'($urandom);
            step(c, a, $urandom, ($urandom_range(0, 19) == 0), 1'b1);
        end

        // Reset on the edge following a read discards the response
        step(c_WR,   8'h00, 32'hA5A5_A5A5, 1'b0, 1'b1);
        step(c_RD,   8'h00, 32'h0, 1'b0, 1'b1);
        step(c_IDLE, 8'h00, 32'h0, 1'b0, 1'b0);
        chk("rst_rv", {31'b0, bus.cmd_rvalid_o}, 32'd0);
        chk("rst_dat", bus.cmd_data_o, 32'h0);
        step(c_RD,   8'h00, 32'h0, 1'b0, 1'b1);
        chk("rst_rd0", bus.cmd_data_o, 32'h0);

        // Reset on the very edge that samples a read
        step(c_WR,   8'h00, 32'h5A5A_5A5A, 1'b0, 1'b1);
        step(c_RD,   8'h00, 32'h0, 1'b0, 1'b0);
        chk("rst2_rv", {31'b0, bus.cmd_rvalid_o}, 32'd0);
        step(c_RD,   8'h00, 32'h0, 1'b0, 1'b1);
        chk("rst2_rd", bus.cmd_data_o, 32'h0);
        step(c_IDLE, 8'h00, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regs_rsp_slave.md
Name: regs_rsp_slave

Overview:
- Responder end of the register command interface: cmd / cmd_addr / cmd_data_w in, cmd_data_r out.
- Decodes IDLE/RD/WR commands issued by the initiator into a small parameterised register bank and returns read data with fixed one-cycle latency.
- Adds protocol checking (invalid command, misaligned or out-of-range address, write to read-only register) and saturating transaction counters.
- Serves as the bench-side reference responder and as a lightweight register block in the subsystem.

Parameters:
- ADDR_W, 8, command address width (byte address)
- DATA_W, 32, data width
- NUM_REGS, 8, number of 32-bit registers; word index = cmd_addr_i[ADDR_W-1:2]
- RO_MASK, 8'h80, bit i set = register i is read-only
- ID_VAL, 32'h5245_4753, reset/fixed value of every read-only register
- ERR_DATA, 32'hDEAD_BEEF, data returned by an erroneous read

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; synchronous and active-low
- cmd_i  in  2  command: 2'b00 IDLE, 2'b01 RD, 2'b10 WR, 2'b11 invalid
- cmd_addr_i  in  ADDR_W  byte address
- cmd_data_i  in  DATA_W  write data
- cmd_data_o  out  DATA_W  read data
- cmd_rvalid_o  out  1  one-cycle pulse, cmd_data_o updated
- cmd_err_o  out  1  one-cycle pulse, the previous-cycle command was erroneous
- cnt_clr_i  in  1  synchronous clear of all counters
- wr_cnt_o  out  16  accepted writes, saturating
- rd_cnt_o  out  16  accepted reads, saturating
- err_cnt_o  out  8  errors, saturating

Behaviour:
- All logic is clocked on posedge clk_i. No combinational path from inputs to outputs.
- Reset (rstn_i==0 at a posedge):
  - RW registers = 0; RO registers = ID_VAL.
  - cmd_data_o = 0; cmd_rvalid_o = 0; cmd_err_o = 0; all counters = 0.
  - Reset mid-stream discards any pending response. The first command is sampled on the first posedge with rstn_i==1.
- Sampling: every posedge with cmd_i != IDLE is one transaction. Back-to-back transactions every cycle are supported; no handshake or backpressure.
- Error classification, evaluated on the sampled inputs:
  - E_CMD: cmd_i==2'b11.
  - E_ALIGN: cmd_addr_i[1:0] != 0.
  - E_RANGE: word index >= NUM_REGS.
  - E_RO: WR to a register whose RO_MASK bit is set.
  - If any error is present: cmd_err_o=1 on the next cycle, err_cnt increments, and no register or rd/wr counter changes.
- WR, no error: register[index] <= cmd_data_i at the sampling edge; wr_cnt increments; no rvalid pulse.
- RD, no error: at the sampling edge, cmd_data_o <= register[index], cmd_rvalid_o <= 1, rd_cnt increments. Data is visible the cycle after the command (latency 1).
- RD with error: cmd_data_o <= ERR_DATA, cmd_rvalid_o <= 1, cmd_err_o <= 1.
- Output hold rules:
  - cmd_data_o holds its last value until the next read response.
  - cmd_rvalid_o and cmd_err_o are low in every cycle not following a qualifying command.
- Read-after-write: a RD sampled the cycle after a WR to the same index returns the newly written data.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr_i==1 forces all counters to 0 on that edge and takes priority over a same-cycle increment.
  - The register access itself still completes normally.
- IDLE: cmd_addr_i and cmd_data_i are ignored; no state changes.

Test Plan:
- Reset, then WR addr 8'h00 data 32'hFFFF_FFFF, RD addr 8'h00, IDLE -> cmd_data_o=32'hFFFF_FFFF with cmd_rvalid_o=1 exactly one cycle after the RD; wr_cnt_o=1, rd_cnt_o=1, err_cnt_o=0.
- Back-to-back WR 8'h04=32'h1234_5678 then RD 8'h04 in the next cycle -> read returns 32'h1234_5678 (read-after-write); then RD 8'h1C -> returns 32'h5245_4753.
- WR 8'h1C=32'h0, cmd_i=2'b11, RD 8'h02, RD 8'h20 -> four cmd_err_o pulses; the two reads return 32'hDEAD_BEEF with rvalid; 8'h1C still reads 32'h5245_4753; err_cnt_o=4.
- Drive 256 consecutive errors -> err_cnt_o saturates at 8'hFF and does not wrap.
- Assert cnt_clr_i in the same cycle as a valid WR -> counters read 0 next cycle, and the write is still visible on a subsequent RD.
- Issue RD 8'h00 with rstn_i low on the response edge -> cmd_rvalid_o=0, cmd_data_o=0, and a subsequent RD 8'h00 returns 0.
